db15_serial_joy_scanner: RTL
============================

// Module: db15_serial_joy_scanner
// PURPOSE
//  Upstream stage of the DB15 user-port joystick path. Scans a 32-bit 74HC165-style shift-register
//  chain by driving JOY_LOAD/JOY_CLK and sampling JOY_DATA. Publishes two debounced active-high
//  16-bit player words for the joystick mux, which selects them in place of the USB joysticks.
//  Player-word bit layout is LS FEDCBAUDLR: [0]R [1]L [2]D [3]U [4]A..[9]F [10]S [11]L.
// PARAMETERS
//  CLK_DIV     48   clk cycles per tick (1 us at 48 MHz); legal range >= 2
//  SCAN_TICKS  935  idle ticks between frames; frame period = (SCAN_TICKS+65)*CLK_DIV clk
//  FILTER      1    1 = publish only when two consecutive frames match; 0 = publish every frame
// PORTS
//  clk        in   1   system clock, 40-50 MHz
//  rst_n      in   1   asynchronous active-low reset
//  JOY_DATA   in   1   serial data from the chain; active-low buttons; already synchronised upstream
//  JOY_CLK    out  1   shift clock to the chain; idles low
//  JOY_LOAD   out  1   parallel-load strobe, active low; idles high
//  joystick1  out  16  player 1 buttons, active high (serial bits 15:0, inverted)
//  joystick2  out  16  player 2 buttons, active high (serial bits 31:16, inverted)
//  frame_done out  1   one-clk pulse in the COMMIT cycle of every frame
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - JOY_LOAD=1, JOY_CLK=0; joystick1/2=0; frame_done=0.
//   - state=IDLE; divider, tick count and bit index = 0; prev_frame = 32'hFFFF_FFFF (all released).
//  tick: free-running divider, 0..CLK_DIV-1; tick=1 for one clk when it reaches CLK_DIV-1.
//   The divider never stops or resynchronises mid-frame.
//  FSM; all transitions occur on tick unless stated otherwise:
//   IDLE:   count ticks; on the SCAN_TICKS-th tick -> LOAD, JOY_LOAD<=0.
//   LOAD:   on next tick -> SHIFT_LO, JOY_LOAD<=1, idx<=0. JOY_LOAD low width is exactly CLK_DIV clk.
//   SHIFT_LO: on tick, raw[idx]<=JOY_DATA and JOY_CLK<=1 in the same clk -> SHIFT_HI.
//             Sampling happens before the rising edge.
//   SHIFT_HI: on tick JOY_CLK<=0; if idx==31 -> COMMIT, else idx<=idx+1 -> SHIFT_LO.
//   COMMIT: single clk, independent of tick; frame_done=1, then -> IDLE with tick count=0.
//     - If FILTER==0 or raw==prev_frame: joystick1<=~raw[15:0], joystick2<=~raw[31:16].
//     - prev_frame<=raw unconditionally.
//  Result: exactly 32 JOY_CLK rising edges per frame, each high for CLK_DIV clk.
//  Output latency: a button change seen in frame N appears after COMMIT of frame N+1 (FILTER=1)
//   or frame N (FILTER=0). Outputs hold their value between COMMITs.
//  No unconnected-adapter detection: a floating-high JOY_DATA reads as all-released (outputs 0).
//  Reset mid-frame aborts the scan immediately: JOY_CLK=0, JOY_LOAD=1, partial raw is discarded,
//   outputs=0. The first frame after reset starts with a full IDLE period.
//  Widths: idx 5 bits; tick count ceil(log2(SCAN_TICKS+1)) bits; no arithmetic wraps inside a frame.
// TESTING
//  1 Hold rst_n=0 -> JOY_LOAD=1, JOY_CLK=0, joystick1/2=0, frame_done=0. Repeat with rst_n
//    asserted mid-SHIFT -> the same values within the same clk.
//  2 CLK_DIV=4, SCAN_TICKS=8, FILTER=0; chain model returns 32'hFFFF_FFFE (P1 R pressed) ->
//    after first COMMIT joystick1=16'h0001, joystick2=0; frame_done pulses once.
//  3 Same setup, count per frame -> 32 JOY_CLK rises; JOY_LOAD low exactly 4 clk;
//    frame_done period = (8+65)*4 = 292 clk.
//  4 FILTER=1; frames A=32'h7FFF_FFFF, B=32'hFFFF_FFFF, then A, A -> outputs stay 0 through the
//    A,B,A sequence; joystick2=16'h8000 after COMMIT of the second consecutive A.
//  5 JOY_DATA tied 1 for 10 frames -> outputs remain 0; frame_done keeps pulsing.
//  6 Toggle JOY_DATA only while JOY_CLK=1 (HI phase) -> captured bits reflect the SHIFT_LO
//    sample values, never the HI-phase values.

Source files
------------

// File: rtl/db15_serial_joy_scanner_if.sv
`default_nettype none
// ============================================================================
// Module      : db15_serial_joy_scanner_if
// Description : Bundles the DB15 shift-register chain pins and the published
//               player words between the scanner and its consumers.
//   JOY_DATA   chain -> scanner, serial data (active-low buttons)
//   JOY_CLK    scanner -> chain, shift clock (idles low)
//   JOY_LOAD   scanner -> chain, parallel-load strobe (active low)
//   joystick1  player 1 word, active high
//   joystick2  player 2 word, active high
//   frame_done one-clk pulse when a frame commits
// Revision    : 1.0 - initial release
// ============================================================================
interface db15_serial_joy_scanner_if;
  logic        JOY_DATA;
  logic        JOY_CLK;
  logic        JOY_LOAD;
  logic [15:0] joystick1;
  logic [15:0] joystick2;
  logic        frame_done;

  modport master (
    input  JOY_DATA,
    output JOY_CLK, JOY_LOAD, joystick1, joystick2, frame_done
  );

  modport slave (
    output JOY_DATA,
    input  JOY_CLK, JOY_LOAD, joystick1, joystick2, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/db15_serial_joy_scanner.sv
`default_nettype none
// ============================================================================
// Module      : db15_serial_joy_scanner
// Description : Scans a 32-bit 74HC165-style chain (JOY_LOAD/JOY_CLK out,
//               JOY_DATA in) once per frame and publishes two optionally
//               debounced active-high 16-bit player words.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   joy    chain pins, player words and frame_done pulse (master side)
// Revision    : 1.0 - initial release
// ============================================================================
module db15_serial_joy_scanner #(
  parameter int CLK_DIV    = 48,
  parameter int SCAN_TICKS = 935,
  parameter bit FILTER     = 1'b1
) (
  input  wire                          clk,
  input  wire                          rst_n,
  db15_serial_joy_scanner_if.master    joy
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TC_W  = (SCAN_TICKS > 0) ? $clog2(SCAN_TICKS + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_SHIFT_LO = 3'd2,
    S_SHIFT_HI = 3'd3,
    S_COMMIT   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [TC_W-1:0]   tcnt_q, tcnt_d;
  logic [4:0]        idx_q, idx_d;
  logic [31:0]       raw_q, raw_d;
  logic [31:0]       prev_q, prev_d;
  logic              load_q, load_d;
  logic              sclk_q, sclk_d;
  logic [15:0]       j1_q, j1_d;
  logic [15:0]       j2_q, j2_d;
  logic              tick;

  // Free-running divider; it is never restarted by the FSM, so the frame
  // period is an exact multiple of CLK_DIV.
  assign tick  = (div_q == DIV_W'(CLK_DIV - 1));
  assign div_d = tick ? '0 : div_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      tcnt_q  <= '0;
      idx_q   <= '0;
      raw_q   <= '1;
      prev_q  <= '1;
      load_q  <= 1'b1;
      sclk_q  <= 1'b0;
      j1_q    <= '0;
      j2_q    <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tcnt_q  <= tcnt_d;
      idx_q   <= idx_d;
      raw_q   <= raw_d;
      prev_q  <= prev_d;
      load_q  <= load_d;
      sclk_q  <= sclk_d;
      j1_q    <= j1_d;
      j2_q    <= j2_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    idx_d   = idx_q;
    raw_d   = raw_q;
    prev_d  = prev_q;
    load_d  = load_q;
    sclk_d  = sclk_q;
    j1_d    = j1_q;
    j2_d    = j2_q;

    case (state_q)
      S_IDLE: begin
        if (tick) begin
          if (tcnt_q == TC_W'(SCAN_TICKS - 1)) begin
            state_d = S_LOAD;
            load_d  = 1'b0;
            tcnt_d  = '0;
          end else begin
            tcnt_d  = tcnt_q + 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (tick) begin
          state_d = S_SHIFT_LO;
          load_d  = 1'b1;
          idx_d   = '0;
        end
      end
      S_SHIFT_LO: begin
        // Data is taken in the same clk that raises JOY_CLK, i.e. before
        // the chain sees the rising edge and advances.
        if (tick) begin
          raw_d[idx_q] = joy.JOY_DATA;
          sclk_d       = 1'b1;
          state_d      = S_SHIFT_HI;
        end
      end
      S_SHIFT_HI: begin
        if (tick) begin
          sclk_d = 1'b0;
          if (idx_q == 5'd31) begin
            state_d = S_COMMIT;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = S_SHIFT_LO;
          end
        end
      end
      S_COMMIT: begin
        // Debounce: publish only when this frame equals the previous one.
        if (!FILTER || (raw_q == prev_q)) begin
          j1_d = ~raw_q[15:0];
          j2_d = ~raw_q[31:16];
        end
        prev_d  = raw_q;
        tcnt_d  = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign joy.JOY_CLK    = sclk_q;
  assign joy.JOY_LOAD   = load_q;
  assign joy.joystick1  = j1_q;
  assign joy.joystick2  = j2_q;
  assign joy.frame_done = (state_q == S_COMMIT);

endmodule
`default_nettype wire
